// File: rtl/cpu_pkg.sv
// Shared constants for the teaching CPU datapath.
// This file holds the ALU function codes, the one-hot beat encoding and the opcode map.
package cpu_pkg;

    // ALU function codes used when M=0 (arithmetic)
    localparam logic [3:0] ALU_ADD    = 4'b1001;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_INC    = 4'b0000;
    localparam logic [3:0] ALU_DEC    = 4'b1111;

    // ALU function codes used when M=1 (logic)
    localparam logic [3:0] ALU_AND    = 4'b1011;
    localparam logic [3:0] ALU_OR     = 4'b1110;
    localparam logic [3:0] ALU_XOR    = 4'b0110;
    localparam logic [3:0] ALU_NOT    = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;
    localparam logic [3:0] ALU_PASS_A = 4'b1111;

    typedef enum logic [2:0] {
        BEAT_W1 = 3'b001,
        BEAT_W2 = 3'b010,
        BEAT_W3 = 3'b100
    } beat_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_LD  = 4'b0101;
    localparam logic [3:0] OP_ST  = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_STP = 4'b1110;

    function automatic logic [7:0] sext4(input logic [3:0] value);
        return {{4{value[3]}}, value};
    endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Interface between the hardwired controller/console and the datapath.
// The controller drives the strobes and the datapath returns its status.
interface cpu_datapath_if;
    logic       SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC;
    logic       CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG;
    logic [3:0] S;
    logic [3:0] SEL;
    logic       QD;
    logic [7:0] SD;

    logic [3:0] IR;
    logic       C, Z;
    logic [2:0] W;
    logic [7:0] DBUS;
    logic [7:0] PC, AR;
    logic       RUN;
    logic       BUSERR;

    modport master (
        output SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC,
               CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG, S, SEL, QD, SD,
        input  IR, C, Z, W, DBUS, PC, AR, RUN, BUSERR
    );

    modport slave (
        input  SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC,
               CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG, S, SEL, QD, SD,
        output IR, C, Z, W, DBUS, PC, AR, RUN, BUSERR
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU. CIN is active-low, so the carry added is ~cin.
// Logic mode always reports a carry of zero.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [7:0] result,
    output logic       carry
);

    logic [8:0] sum;
    logic [8:0] ci;

    assign ci = {8'h00, ~cin};

    always_comb begin
        sum    = 9'h000;
        result = 8'h00;
        carry  = 1'b0;
        if (!m) begin
            case (s)
                ALU_ADD: sum = {1'b0, a} + {1'b0, b} + ci;
                ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + ci;
                ALU_DEC: sum = {1'b0, a} + 9'h0FF + ci;
                default: sum = {1'b0, a} + ci;
            endcase
            result = sum[7:0];
            carry  = sum[8];
        end else begin
            case (s)
                ALU_AND:    result = a & b;
                ALU_OR:     result = a | b;
                ALU_XOR:    result = a ^ b;
                ALU_NOT:    result = ~a;
                ALU_PASS_B: result = b;
                default:    result = a;
            endcase
        end
    end

endmodule

// File: rtl/cpu_datapath.sv
// Datapath of the teaching CPU: four registers, PC, AR, IR, flags, a 256x8 memory and the beat generator.
// All state changes happen on the rising edge of T3, and only while RUN is high.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic          T3,
    input  logic          CLR,
    cpu_datapath_if.slave bus
);

    logic [7:0] regs [4];
    logic [7:0] mem  [256];
    logic [7:0] pc_q, ar_q, ir_q;
    logic       c_q, z_q;
    beat_t      beat_q, beat_next;
    logic       run_q, run_next;

    logic [1:0] a_sel, b_sel;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [1:0] source_count;
    logic       bus_err;
    logic [7:0] dbus;

    assign a_sel = bus.SELCTL ? bus.SEL[3:2] : ir_q[3:2];
    assign b_sel = bus.SELCTL ? bus.SEL[1:0] : ir_q[1:0];

    cpu_alu alu (
        .a      (regs[a_sel]),
        .b      (regs[b_sel]),
        .s      (bus.S),
        .m      (bus.M),
        .cin    (bus.CIN),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // More than one bus driver is a conflict: the bus reads as zero instead of picking a winner
    assign source_count = {1'b0, bus.SBUS} + {1'b0, bus.MBUS} + {1'b0, bus.ABUS};
    assign bus_err      = source_count > 2'd1;

    always_comb begin
        dbus = 8'h00;
        if (!bus_err) begin
            if (bus.SBUS)      dbus = bus.SD;
            else if (bus.MBUS) dbus = mem[ar_q];
            else if (bus.ABUS) dbus = alu_result;
        end
    end

    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
            pc_q <= 8'h00;
            ar_q <= 8'h00;
            ir_q <= 8'h00;
            c_q  <= 1'b0;
            z_q  <= 1'b0;
        end else if (run_q) begin
            if (bus.DRW) regs[a_sel] <= dbus;
            if (bus.LPC)        pc_q <= dbus;
            else if (bus.PCADD) pc_q <= pc_q + sext4(ir_q[3:0]);
            else if (bus.PCINC) pc_q <= pc_q + 8'h01;
            if (bus.LAR)        ar_q <= dbus;
            else if (bus.ARINC) ar_q <= ar_q + 8'h01;
            if (bus.LIR) ir_q <= mem[pc_q];
            if (bus.LDC) c_q  <= alu_carry;
            if (bus.LDZ) z_q  <= (alu_result == 8'h00);
        end
    end

    // Memory contents survive reset, so this store has no reset branch
    always_ff @(posedge T3) begin
        if (run_q && bus.MEMW) mem[ar_q] <= dbus;
    end

    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            beat_q <= BEAT_W1;
            run_q  <= 1'b0;
        end else begin
            beat_q <= beat_next;
            run_q  <= run_next;
        end
    end

    always_comb begin
        beat_next = beat_q;
        run_next  = run_q;
        if (run_q) begin
            case (beat_q)
                BEAT_W1: beat_next = bus.SHORT ? BEAT_W1 : BEAT_W2;
                BEAT_W2: beat_next = bus.LONG ? BEAT_W3 : BEAT_W1;
                BEAT_W3: beat_next = BEAT_W1;
                default: beat_next = BEAT_W1;
            endcase
            if (bus.STOP) run_next = 1'b0;
        end else if (bus.QD) begin
            run_next = 1'b1;
        end
    end

    assign bus.IR     = ir_q[7:4];
    assign bus.C      = c_q;
    assign bus.Z      = z_q;
    assign bus.W      = beat_q;
    assign bus.DBUS   = dbus;
    assign bus.PC     = pc_q;
    assign bus.AR     = ar_q;
    assign bus.RUN    = run_q;
    assign bus.BUSERR = bus_err;

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: expected values are queued as stimulus is driven
// and compared against the DUT once the corresponding edge or settle time has passed.
module tb_cpu_datapath;

    logic T3;
    logic CLR;

    cpu_datapath_if bus ();

    cpu_datapath dut (
        .T3  (T3),
        .CLR (CLR),
        .bus (bus)
    );

    initial T3 = 1'b0;
    always #5 T3 = ~T3;

    localparam int OBS_DBUS   = 0;
    localparam int OBS_PC     = 1;
    localparam int OBS_AR     = 2;
    localparam int OBS_IR     = 3;
    localparam int OBS_C      = 4;
    localparam int OBS_Z      = 5;
    localparam int OBS_W      = 6;
    localparam int OBS_RUN    = 7;
    localparam int OBS_BUSERR = 8;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } expect_t;

    expect_t sbQueue[$];
    int checkCount = 0;
    int errorCount = 0;

    function automatic logic [7:0] getObs(input int sel);
        case (sel)
            OBS_DBUS:   return bus.DBUS;
            OBS_PC:     return bus.PC;
            OBS_AR:     return bus.AR;
            OBS_IR:     return {4'h0, bus.IR};
            OBS_C:      return {7'h00, bus.C};
            OBS_Z:      return {7'h00, bus.Z};
            OBS_W:      return {5'h00, bus.W};
            OBS_RUN:    return {7'h00, bus.RUN};
            OBS_BUSERR: return {7'h00, bus.BUSERR};
            default:    return 8'hxx;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic expectValue(input string tag, input int sel, input logic [7:0] val);
        expect_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbQueue.push_back(e);
    endtask

    task automatic drainScoreboard();
        expect_t e;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            checkOutput(e.tag, getObs(e.sel), e.val);
        end
    endtask

    // Combinational check: inputs were just driven at a falling edge
    task automatic settleCheck();
        #1;
        drainScoreboard();
    endtask

    // One rising edge, then compare and return to the next falling edge
    task automatic applyStimulus();
        @(posedge T3);
        #1;
        drainScoreboard();
        @(negedge T3);
    endtask

    task automatic clearControls();
        {bus.SELCTL, bus.DRW, bus.LPC, bus.PCINC, bus.PCADD, bus.LAR, bus.ARINC, bus.LIR} = '0;
        {bus.LDZ, bus.LDC, bus.CIN, bus.M, bus.MEMW, bus.ABUS, bus.SBUS, bus.MBUS} = '0;
        {bus.STOP, bus.SHORT, bus.LONG, bus.QD} = '0;
        bus.S   = 4'h0;
        bus.SEL = 4'h0;
        bus.SD  = 8'h00;
    endtask

    task automatic startRun();
        clearControls();
        bus.QD = 1'b1;
        applyStimulus();
        clearControls();
    endtask

    task automatic loadReg(input logic [1:0] idx, input logic [7:0] val);
        clearControls();
        bus.SELCTL = 1'b1;
        bus.SEL    = {idx, 2'b00};
        bus.SBUS   = 1'b1;
        bus.SD     = val;
        bus.DRW    = 1'b1;
        bus.SHORT  = 1'b1;
        applyStimulus();
        clearControls();
    endtask

    task automatic readReg(input logic [1:0] idx, input logic [7:0] val, input string tag);
        clearControls();
        bus.SELCTL = 1'b1;
        bus.SEL    = {idx, 2'b00};
        bus.M      = 1'b1;
        bus.S      = 4'b1111;
        bus.ABUS   = 1'b1;
        expectValue(tag, OBS_DBUS, val);
        settleCheck();
        clearControls();
    endtask

    task automatic loadAr(input logic [7:0] addr);
        clearControls();
        bus.SBUS  = 1'b1;
        bus.SD    = addr;
        bus.LAR   = 1'b1;
        bus.SHORT = 1'b1;
        applyStimulus();
        clearControls();
    endtask

    task automatic writeMem(input logic [7:0] addr, input logic [7:0] data);
        loadAr(addr);
        bus.SBUS  = 1'b1;
        bus.SD    = data;
        bus.MEMW  = 1'b1;
        bus.SHORT = 1'b1;
        applyStimulus();
        clearControls();
    endtask

    task automatic loadPc(input logic [7:0] val);
        clearControls();
        bus.SBUS  = 1'b1;
        bus.SD    = val;
        bus.LPC   = 1'b1;
        bus.SHORT = 1'b1;
        applyStimulus();
        clearControls();
    endtask

    task automatic loadIr();
        clearControls();
        bus.LIR   = 1'b1;
        bus.SHORT = 1'b1;
        applyStimulus();
        clearControls();
    endtask

    task automatic expectResetState(input string tag);
        expectValue({tag, "_pc"}, OBS_PC, 8'h00);
        expectValue({tag, "_ar"}, OBS_AR, 8'h00);
        expectValue({tag, "_ir"}, OBS_IR, 8'h00);
        expectValue({tag, "_c"}, OBS_C, 8'h00);
        expectValue({tag, "_z"}, OBS_Z, 8'h00);
        expectValue({tag, "_w"}, OBS_W, 8'h01);
        expectValue({tag, "_run"}, OBS_RUN, 8'h00);
    endtask

    task automatic doReset();
        clearControls();
        CLR = 1'b0;
        @(negedge T3);
        expectResetState("reset");
        settleCheck();
        CLR = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        CLR = 1'b1;
        clearControls();
        doReset();
        for (int i = 0; i < 4; i++) readReg(i[1:0], 8'h00, "reset_reg");
        expectValue("reset_buserr", OBS_BUSERR, 8'h00);
        expectValue("reset_dbus", OBS_DBUS, 8'h00);
        settleCheck();

        // Console write then stop
        expectValue("start_run", OBS_RUN, 8'h01);
        expectValue("start_w", OBS_W, 8'h01);
        startRun();
        bus.SELCTL = 1'b1; bus.SEL = 4'b1100; bus.SBUS = 1'b1; bus.DRW = 1'b1;
        bus.SD = 8'h5A; bus.STOP = 1'b1;
        expectValue("console_dbus", OBS_DBUS, 8'h5A);
        settleCheck();
        expectValue("stop_run", OBS_RUN, 8'h00);
        expectValue("stop_w", OBS_W, 8'h02);
        applyStimulus();
        readReg(2'd3, 8'h5A, "console_r3");

        // Idle: strobes must not change anything
        bus.SELCTL = 1'b1; bus.SEL = 4'b1100; bus.SBUS = 1'b1; bus.DRW = 1'b1;
        bus.SD = 8'h77; bus.LPC = 1'b1;
        expectValue("idle_pc", OBS_PC, 8'h00);
        expectValue("idle_w", OBS_W, 8'h02);
        applyStimulus();
        readReg(2'd3, 8'h5A, "idle_r3");
        expectValue("restart_w", OBS_W, 8'h02);
        expectValue("restart_run", OBS_RUN, 8'h01);
        startRun();

        // ADD R0,R1
        loadReg(2'd0, 8'hF0);
        loadReg(2'd1, 8'h20);
        writeMem(8'h00, 8'h01);
        loadIr();
        bus.M = 1'b0; bus.S = 4'b1001; bus.CIN = 1'b1; bus.ABUS = 1'b1;
        bus.DRW = 1'b1; bus.LDC = 1'b1; bus.LDZ = 1'b1; bus.SHORT = 1'b1;
        expectValue("add_dbus", OBS_DBUS, 8'h10);
        settleCheck();
        expectValue("add_c", OBS_C, 8'h01);
        expectValue("add_z", OBS_Z, 8'h00);
        applyStimulus();
        readReg(2'd0, 8'h10, "add_r0");

        // ALU functions on A=R0=0x10, B=R1=0x20
        begin
            logic [4:0] modeCode [7];
            logic [7:0] expVal [7];
            modeCode = '{5'b1_1011, 5'b1_1110, 5'b1_0110, 5'b1_0000, 5'b1_1010, 5'b0_0110, 5'b0_1111};
            expVal   = '{8'h00, 8'h30, 8'h30, 8'hEF, 8'h20, 8'hEF, 8'h0F};
            for (int i = 0; i < 7; i++) begin
                clearControls();
                bus.SELCTL = 1'b1; bus.SEL = 4'b0001; bus.ABUS = 1'b1; bus.CIN = 1'b1;
                bus.M = modeCode[i][4];
                bus.S = modeCode[i][3:0];
                expectValue($sformatf("alu_fn%0d", i), OBS_DBUS, expVal[i]);
                settleCheck();
            end
            clearControls();
        end

        // INC wrap on R2 via IR=0x48
        loadReg(2'd2, 8'hFF);
        writeMem(8'h00, 8'h48);
        expectValue("ir_high", OBS_IR, 8'h04);
        loadIr();
        bus.M = 1'b0; bus.S = 4'b0000; bus.CIN = 1'b0; bus.ABUS = 1'b1;
        bus.DRW = 1'b1; bus.LDC = 1'b1; bus.LDZ = 1'b1; bus.SHORT = 1'b1;
        expectValue("inc_c", OBS_C, 8'h01);
        expectValue("inc_z", OBS_Z, 8'h01);
        applyStimulus();
        readReg(2'd2, 8'h00, "inc_r2");

        // Bus conflict and PC priority
        bus.SBUS = 1'b1; bus.MBUS = 1'b1; bus.SD = 8'h33;
        expectValue("conflict_buserr", OBS_BUSERR, 8'h01);
        expectValue("conflict_dbus", OBS_DBUS, 8'h00);
        settleCheck();
        clearControls();
        bus.SBUS = 1'b1; bus.SD = 8'h40; bus.LPC = 1'b1; bus.PCINC = 1'b1; bus.SHORT = 1'b1;
        expectValue("lpc_priority", OBS_PC, 8'h40);
        applyStimulus();
        clearControls();

        // Wraparound of PC and AR
        expectValue("pc_load", OBS_PC, 8'hFF);
        loadPc(8'hFF);
        bus.PCINC = 1'b1; bus.SHORT = 1'b1;
        expectValue("pcinc_wrap", OBS_PC, 8'h00);
        applyStimulus();
        clearControls();
        loadAr(8'hFF);
        bus.ARINC = 1'b1; bus.SHORT = 1'b1;
        expectValue("arinc_wrap", OBS_AR, 8'h00);
        applyStimulus();
        clearControls();
        writeMem(8'h02, 8'h0E);
        loadPc(8'h02);
        loadIr();
        bus.PCADD = 1'b1; bus.SHORT = 1'b1;
        expectValue("pcadd_wrap", OBS_PC, 8'h00);
        applyStimulus();
        clearControls();

        // Beat sequencing
        doReset();
        startRun();
        expectValue("beat_w2", OBS_W, 8'h02);
        applyStimulus();
        bus.LONG = 1'b1;
        expectValue("beat_w3", OBS_W, 8'h04);
        applyStimulus();
        clearControls();
        expectValue("beat_w1", OBS_W, 8'h01);
        applyStimulus();
        bus.SHORT = 1'b1;
        expectValue("beat_short", OBS_W, 8'h01);
        applyStimulus();
        clearControls();
        bus.LONG = 1'b1;
        expectValue("beat_long_ignored", OBS_W, 8'h02);
        applyStimulus();
        clearControls();
        bus.STOP = 1'b1;
        expectValue("beat_stop_w", OBS_W, 8'h01);
        expectValue("beat_stop_run", OBS_RUN, 8'h00);
        applyStimulus();
        clearControls();

        // Reset in the middle of a long W2 beat
        startRun();
        writeMem(8'h10, 8'hA5);
        loadReg(2'd0, 8'h66);
        loadPc(8'h33);
        expectValue("mid_w2", OBS_W, 8'h02);
        applyStimulus();
        bus.LONG = 1'b1;
        #2;
        CLR = 1'b0;
        expectResetState("midreset");
        settleCheck();
        CLR = 1'b1;
        clearControls();
        @(negedge T3);
        readReg(2'd0, 8'h00, "midreset_r0");
        expectValue("post_reset_w", OBS_W, 8'h01);
        startRun();
        loadAr(8'h10);
        bus.MBUS = 1'b1;
        expectValue("mem_retained", OBS_DBUS, 8'hA5);
        settleCheck();
        clearControls();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have port T3  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port CLR  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports SELCTL, DRW, LPC, PCINC, PCADD, LAR, ARINC, LIR, LDZ, LDC, CIN, M, MEMW, ABUS, SBUS, MBUS, STOP, SHORT, LONG  in  1 each  control strobes from the hardwired controller, sampled at T3 rise.
REQ-004 SHALL have ports S  in  4  ALU function and SEL  in  4  console register select (SEL[3:2] write/A, SEL[1:0] B).
REQ-005 SHALL have ports QD  in  1  start pulse and SD  in  8  console data switches.
REQ-006 SHALL have ports IR  out  4  IR[7:4]; C, Z  out  1  flags; W  out  3  one-hot beat (W[1]..W[3]).
REQ-007 SHALL have ports DBUS  out  8  internal bus value; PC, AR  out  8  registers; RUN  out  1  beat generator running; BUSERR  out  1  bus conflict.

Function
REQ-008 SHALL contain R0-R3 (8b), PC, AR, IR (8b), C, Z, and a 256x8 memory MEM.
REQ-009 SHALL select A=R[SEL[3:2]], B=R[SEL[1:0]] when SELCTL=1, else A=R[IR[3:2]], B=R[IR[1:0]]; write destination = A-select.
REQ-010 SHALL drive DBUS: SBUS->SD, MBUS->MEM[AR], ABUS->ALU result, none->0x00; >1 asserted -> DBUS=0x00, BUSERR=1 combinationally.
REQ-011 SHALL compute ALU with ci=~CIN: M=0: S=1001 A+B+ci; S=0110 A+~B+ci; S=0000 A+ci; S=1111 A+0xFF+ci; others A+ci; C_out = bit 8 of 9-bit sum.
REQ-012 SHALL compute M=1: S=1011 A&B; S=1110 A|B; S=0110 A^B; S=0000 ~A; S=1010 B; S=1111 and others A; C_out=0.
REQ-013 SHALL, only when RUN=1 at the edge: DRW: Rdest<=DBUS; LPC: PC<=DBUS; else PCADD: PC<=PC+sext(IR[3:0]); else PCINC: PC<=PC+1.
REQ-014 SHALL, only when RUN=1: LAR: AR<=DBUS, else ARINC: AR<=AR+1; LIR: IR<=MEM[PC] (pre-edge PC); MEMW: MEM[AR]<=DBUS; LDC: C<=C_out; LDZ: Z<=(ALU result==0).
REQ-015 SHALL wrap PC/AR modulo 256 (0xFF+1=0x00; PCADD 0x02+0xE=0x00).
REQ-016 SHALL return pre-write data on MBUS when MEMW targets the same address in the same beat.
REQ-017 SHALL sequence W when RUN=1: W1->W1 if SHORT else W2; W2->W3 if LONG else W1; W3->W1; SHORT/LONG ignored in other beats.
REQ-018 SHALL clear RUN at an edge where RUN=1 and STOP=1, after completing that beat's actions and W advance.
REQ-019 SHALL set RUN at an edge where RUN=0 and QD=1, W unchanged; QD ignored while RUN=1; no register or W change while RUN=0.

Reset
REQ-020 SHALL on CLR=0 immediately set R0-R3, PC, AR, IR, C, Z=0, W=001, RUN=0; MEM not reset.
REQ-021 SHALL abandon any in-progress beat on reset mid-operation; first post-reset beat is W1 after QD.

Structure
REQ-022 SHALL place ALU S-codes, W one-hot constants and opcodes (ADD=0001, SUB=0010, AND=0011, INC=0100, LD=0101, ST=0110, JC=0111, JZ=1000, JMP=1001, STP=1110) in shared package cpu_pkg.
REQ-023 SHALL implement the ALU as combinational sub-module cpu_alu.

Verification
REQ-024 Console write: QD, SELCTL=1, SEL=1100, SBUS=1, DRW=1, SD=0x5A -> R3=0x5A, DBUS=0x5A, RUN=0 after STOP beat.
REQ-025 ADD: R0=0xF0, R1=0x20, IR=0x01, M=0, S=1001, CIN=1, ABUS, DRW, LDC, LDZ -> R0=0x10, C=1, Z=0.
REQ-026 INC wrap: R2=0xFF, IR=0x48, S=0000, M=0, CIN=0 -> R2=0x00, C=1, Z=1.
REQ-027 Beats: RUN=1, LONG at W2 -> W 001,010,100,001; SHORT at W1 -> W stays 001; PCINC at PC=0xFF -> 0x00.
REQ-028 Conflict/priority: SBUS+MBUS -> BUSERR=1, DBUS=0x00; LPC+PCINC with DBUS=0x40 -> PC=0x40.
REQ-029 Reset: CLR=0 during W2 with LONG -> all registers 0, W=001, RUN=0 immediately; MEM[0x10] retains 0xA5.
